indicator_write_ctrl: RTL and testbench

- Sequencer and arbiter for the 16-bit nibble-addressed indicator output register (4 nibble ports, 4-bit write data, write strobe).
- Two requesters each submit a full 16-bit word. The block grants one with round-robin priority and captures its word.
- It then issues four single-cycle nibble writes (port 0..3) to the output register, with an optional idle gap between writes.

---
 rtl/indicator_write_ctrl.sv | 127 ++++++++++++
 tb/tb_indicator_write_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/indicator_write_ctrl.sv
`default_nettype none
//============================================================================
// Module   : indicator_write_ctrl
// Brief    : Round-robin arbiter for two 16-bit word requesters. Writes the
//            granted word as four nibbles to the indicator output register.
// Revision : 1.0 - initial release
//============================================================================
module indicator_write_ctrl #(
    parameter int WR_GAP = 0
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic        req_a,
    input  logic [15:0] data_a,
    output logic        ack_a,
    input  logic        req_b,
    input  logic [15:0] data_b,
    output logic        ack_b,
    output logic        wr,
    output logic [3:0]  Data,
    output logic [1:0]  PortID,
    output logic        busy,
    output logic        done
);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_WRITE = 2'd1;
    localparam logic [1:0] c_ST_GAP   = 2'd2;
    localparam logic [1:0] c_ST_DONE  = 2'd3;
    localparam logic [3:0] c_GAP      = 4'(WR_GAP);

    logic [1:0]  r_state;
    logic [1:0]  r_idx;
    logic [3:0]  r_gap_cnt;
    logic [15:0] r_shadow;
    logic        r_last_b;

    logic        w_grant_a;
    logic        w_grant_b;
    logic [15:0] w_win_data;
    logic [1:0]  w_idx_nxt;
    logic [3:0]  w_nib_nxt;

    // A wins a tie unless A was granted last time.
    assign w_grant_a  = req_a & (~req_b | r_last_b);
    assign w_grant_b  = req_b & ~w_grant_a;
    assign w_win_data = w_grant_a ? data_a : data_b;
    assign w_idx_nxt  = r_idx + 2'd1;
    assign w_nib_nxt  = r_shadow[{w_idx_nxt, 2'b00} +: 4];

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            r_state   <= c_ST_IDLE;
            r_idx     <= 2'd0;
            r_gap_cnt <= 4'd0;
            r_shadow  <= 16'h0000;
            r_last_b  <= 1'b1;
            ack_a     <= 1'b0;
            ack_b     <= 1'b0;
            wr        <= 1'b0;
            Data      <= 4'h0;
            PortID    <= 2'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            ack_a <= 1'b0;
            ack_b <= 1'b0;
            wr    <= 1'b0;
            done  <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    busy <= 1'b0;
                    if (w_grant_a || w_grant_b) begin
                        r_shadow <= w_win_data;
                        r_last_b <= w_grant_b;
                        r_idx    <= 2'd0;
                        r_state  <= c_ST_WRITE;
                        ack_a    <= w_grant_a;
                        ack_b    <= w_grant_b;
                        wr       <= 1'b1;
                        PortID   <= 2'd0;
                        Data     <= w_win_data[3:0];
                        busy     <= 1'b1;
                    end
                end
                c_ST_WRITE: begin
                    if (r_idx == 2'd3) begin
                        r_state <= c_ST_DONE;
                        done    <= 1'b1;
                    end else if (c_GAP == 4'd0) begin
                        r_idx  <= w_idx_nxt;
                        wr     <= 1'b1;
                        PortID <= w_idx_nxt;
                        Data   <= w_nib_nxt;
                    end else begin
                        r_gap_cnt <= c_GAP;
                        r_state   <= c_ST_GAP;
                    end
                end
                c_ST_GAP: begin
                    // Counter is loaded with the gap length, so the write
                    // for the next nibble is issued on the edge it hits 1.
                    if (r_gap_cnt == 4'd1) begin
                        r_gap_cnt <= 4'd0;
                        r_idx     <= w_idx_nxt;
                        r_state   <= c_ST_WRITE;
                        wr        <= 1'b1;
                        PortID    <= w_idx_nxt;
                        Data      <= w_nib_nxt;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - 4'd1;
                    end
                end
                c_ST_DONE: begin
                    busy    <= 1'b0;
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_indicator_write_ctrl.sv
`default_nettype none
//============================================================================
// Module   : tb_indicator_write_ctrl
// Brief    : Bench for indicator_write_ctrl with WR_GAP=0 and WR_GAP=2 copies.
// Revision : 1.0 - initial release
//============================================================================
module tb_indicator_write_ctrl;

    logic        clk   = 1'b0;
    logic        Reset = 1'b0;
    logic        req_a  [2];
    logic        req_b  [2];
    logic [15:0] data_a [2];
    logic [15:0] data_b [2];
    logic        ack_a  [2];
    logic        ack_b  [2];
    logic        wr     [2];
    logic [3:0]  Data   [2];
    logic [1:0]  PortID [2];
    logic        busy   [2];
    logic        done   [2];
    logic [15:0] ind    [2];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    indicator_write_ctrl #(.WR_GAP(0)) dut0 (
        .clk(clk), .Reset(Reset),
        .req_a(req_a[0]), .data_a(data_a[0]), .ack_a(ack_a[0]),
        .req_b(req_b[0]), .data_b(data_b[0]), .ack_b(ack_b[0]),
        .wr(wr[0]), .Data(Data[0]), .PortID(PortID[0]),
        .busy(busy[0]), .done(done[0])
    );

    indicator_write_ctrl #(.WR_GAP(2)) dut2 (
        .clk(clk), .Reset(Reset),
        .req_a(req_a[1]), .data_a(data_a[1]), .ack_a(ack_a[1]),
        .req_b(req_b[1]), .data_b(data_b[1]), .ack_b(ack_b[1]),
        .wr(wr[1]), .Data(Data[1]), .PortID(PortID[1]),
        .busy(busy[1]), .done(done[1])
    );

    // Indicator register: not cleared by Reset, so partial writes remain visible.
    always @(posedge clk) begin
        if (wr[0]) ind[0][{PortID[0], 2'b00} +: 4] <= Data[0];
        if (wr[1]) ind[1][{PortID[1], 2'b00} +: 4] <= Data[1];
    end

    // Model: a transaction is described by its offset t from the grant edge.
    logic        m_act  [2];
    logic        m_any  [2];
    logic        m_lastb[2];
    int          m_t    [2];
    logic [15:0] m_sh   [2];

    function automatic int gap(int k);
        return (k == 0) ? 0 : 2;
    endfunction

    always @(posedge clk or posedge Reset) begin
        if (Reset) begin
            for (int k = 0; k < 2; k++) begin
                m_act[k]   <= 1'b0;
                m_any[k]   <= 1'b0;
                m_lastb[k] <= 1'b1;
                m_t[k]     <= 0;
                m_sh[k]    <= 16'h0000;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (!m_act[k]) begin
                    if (req_a[k] && (!req_b[k] || m_lastb[k])) begin
                        m_act[k] <= 1'b1; m_any[k] <= 1'b1; m_t[k] <= 1;
                        m_sh[k]  <= data_a[k]; m_lastb[k] <= 1'b0;
                    end else if (req_b[k]) begin
                        m_act[k] <= 1'b1; m_any[k] <= 1'b1; m_t[k] <= 1;
                        m_sh[k]  <= data_b[k]; m_lastb[k] <= 1'b1;
                    end
                end else if (m_t[k] == 5 + 3 * gap(k)) begin
                    m_act[k] <= 1'b0;
                    m_t[k]   <= 0;
                end else begin
                    m_t[k] <= m_t[k] + 1;
                end
            end
        end
    end

    // Writes fall at t = 1 + n*(gap+1) for n = 0..3; done at t = 5 + 3*gap.
    function automatic logic [10:0] exp_vec(int k);
        int   g;
        int   t;
        int   idx;
        logic wr_e;
        g    = gap(k);
        t    = m_t[k];
        idx  = 3;
        wr_e = 1'b0;
        if (m_act[k]) begin
            if ((t - 1) / (g + 1) < 3) idx = (t - 1) / (g + 1);
            wr_e = ((t - 1) % (g + 1) == 0) && ((t - 1) / (g + 1) < 4);
        end
        return {m_act[k] && t == 1 && !m_lastb[k],
                m_act[k] && t == 1 && m_lastb[k],
                wr_e,
                m_any[k] ? m_sh[k][4*idx +: 4] : 4'h0,
                m_any[k] ? 2'(idx) : 2'b00,
                m_act[k],
                m_act[k] && t == 5 + 3 * g};
    endfunction

    function automatic logic [10:0] dut_vec(int k);
        return {ack_a[k], ack_b[k], wr[k], Data[k], PortID[k], busy[k], done[k]};
    endfunction

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            n_tests++;
            if (dut_vec(k) !== exp_vec(k)) begin
                n_fail++;
                $display("FAIL model_cmp inst%0d @%0t got={ackA,ackB,wr,Data,Port,busy,done}=%b expected=%b",
                         k, $time, dut_vec(k), exp_vec(k));
            end
        end
    end

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic wait_idle(int k);
        int n = 0;
        while (busy[k] && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("wait_idle_bound", 32'(n < 50), 32'd1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        Reset = 1'b1;
        @(negedge clk);
        Reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] mask;
        logic [15:0] word;
        int          cyc;
        int          cnt;

        for (int k = 0; k < 2; k++) begin
            req_a[k] = 1'b0; req_b[k] = 1'b0;
            data_a[k] = 16'h0; data_b[k] = 16'h0;
        end
        #1 Reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_out_g0", 32'(dut_vec(0)), 32'h0);
        chk("reset_out_g2", 32'(dut_vec(1)), 32'h0);
        Reset = 1'b0;
        @(negedge clk);

        // Single word, back-to-back nibbles
        data_a[0] = 16'hBEEF; req_a[0] = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (c == 1) begin
                chk("t1_ack_a", 32'(ack_a[0]), 32'd1);
                chk("t1_wr_nib0", 32'({wr[0], PortID[0], Data[0]}), 32'h4F);
                req_a[0] = 1'b0;
            end
            if (c == 4) chk("t1_wr_nib3", 32'({wr[0], PortID[0], Data[0]}), 32'h7B);
            if (c == 5) chk("t1_done", 32'({done[0], busy[0], wr[0]}), 32'h6);
            if (c == 6) chk("t1_idle", 32'({done[0], busy[0]}), 32'h0);
        end
        chk("t1_ind", 32'(ind[0]), 32'hBEEF);

        // Joint contention after reset: A then B, then A again
        do_reset();
        data_a[0] = 16'h1234; data_b[0] = 16'hABCD;
        req_a[0] = 1'b1; req_b[0] = 1'b1;
        @(posedge clk);
        cyc = 0;
        for (int c = 1; c <= 13; c++) begin
            @(negedge clk);
            if (c == 1) chk("t2_a_first", 32'({ack_a[0], ack_b[0]}), 32'h2);
            if (ack_a[0]) req_a[0] = 1'b0;
            if (ack_b[0]) begin req_b[0] = 1'b0; cyc = c; end
        end
        chk("t2_ack_b_cycle", 32'(cyc), 32'd7);
        chk("t2_ind", 32'(ind[0]), 32'hABCD);
        data_a[0] = 16'h1111; data_b[0] = 16'h2222;
        req_a[0] = 1'b1; req_b[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("t2_third_grant_a", 32'({ack_a[0], ack_b[0]}), 32'h2);
        req_a[0] = 1'b0; req_b[0] = 1'b0;
        wait_idle(0);

        // WR_GAP=2 instance
        data_b[1] = 16'h5A3C; req_b[1] = 1'b1;
        @(posedge clk);
        mask = 0; word = 0; cyc = 0;
        for (int c = 1; c <= 13; c++) begin
            @(negedge clk);
            if (c == 1) req_b[1] = 1'b0;
            if (wr[1]) begin
                mask = mask | (32'd1 << c);
                word = {Data[1], word[15:4]};
            end
            if (done[1]) cyc = c;
        end
        chk("t3_wr_cycles", mask, 32'h492);
        chk("t3_nibbles", 32'(word), 32'h5A3C);
        chk("t3_done_cycle", 32'(cyc), 32'd11);

        // Asynchronous reset between 2nd and 3rd writes
        data_a[1] = 16'hCAFE; req_a[1] = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c == 1) req_a[1] = 1'b0;
        end
        #2 Reset = 1'b1;
        #1 chk("t4_async_reset", 32'(dut_vec(1)), 32'h0);
        @(negedge clk);
        Reset = 1'b0;
        cnt = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (wr[1]) cnt++;
        end
        chk("t4_no_more_wr", 32'(cnt), 32'd0);
        chk("t4_ind_partial", 32'(ind[1]), 32'h5AFE);
        data_a[1] = 16'h0001; req_a[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("t4_regrant", 32'(ack_a[1]), 32'd1);
        req_a[1] = 1'b0;
        wait_idle(1);

        // Continuous request: one word every 6 cycles
        data_a[0] = 16'h0F0F; req_a[0] = 1'b1;
        @(posedge clk);
        mask = 0;
        for (int c = 1; c <= 19; c++) begin
            @(negedge clk);
            if (ack_a[0]) mask = mask | (32'd1 << c);
        end
        chk("t5_ack_cycles", mask, 32'h82082);
        req_a[0] = 1'b0;
        wait_idle(0);

        // Lost pulse while busy; data change after capture
        data_a[0] = 16'h1357; req_a[0] = 1'b1;
        @(posedge clk);
        cnt = 0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 1) req_a[0] = 1'b0;
            if (c == 2) begin data_a[0] = 16'hFFFF; req_b[0] = 1'b1; end
            if (c == 3) req_b[0] = 1'b0;
            if (ack_b[0]) cnt++;
        end
        chk("t6_lost_req_b", 32'(cnt), 32'd0);
        chk("t6_captured_data", 32'(ind[0]), 32'h1357);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
